// File: rtl/tri_if.sv
// Vertex-in / triangle-out handshake bundle for the triangle assembler.
interface tri_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_x;
    logic signed [31:0] in_y;
    logic               cull_en;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_x0;
    logic signed [15:0] out_y0;
    logic signed [15:0] out_x1;
    logic signed [15:0] out_y1;
    logic signed [15:0] out_x2;
    logic signed [15:0] out_y2;
    logic signed [31:0] out_area;
    logic        [15:0] stat_emitted;
    logic        [15:0] stat_culled;

    modport master (
        output in_valid, in_x, in_y, cull_en, out_ready,
        input  in_ready, out_valid, out_x0, out_y0, out_x1, out_y1, out_x2, out_y2,
        input  out_area, stat_emitted, stat_culled
    );

    modport slave (
        input  in_valid, in_x, in_y, cull_en, out_ready,
        output in_ready, out_valid, out_x0, out_y0, out_x1, out_y1, out_x2, out_y2,
        output out_area, stat_emitted, stat_culled
    );
endinterface

// File: rtl/tri_assembler.sv
// Groups a stream of window-space vertices into triangles, rounds them to
// integer pixels, computes signed twice-area, trivially rejects / back-face
// culls, and queues surviving triangles in a small show-ahead FIFO.
module tri_assembler #(
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = 600,
    parameter int SCREEN_H   = 600
) (
    input  logic clk,
    input  logic rst,
    tri_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = 6 * 16 + 32;

    typedef enum logic [2:0] {S_V0, S_V1, S_V2, S_EVAL, S_STALL} state_t;

    // Q16.16 to integer pixel, round half up; the 33-bit sum keeps
    // 0x7FFFFFFF + 0x8000 from overflowing before the clamp.
    function automatic logic signed [15:0] round_px(input logic signed [31:0] q);
        logic        [32:0] sum;
        logic signed [16:0] px;
        sum = {q[31], q} + 33'h0_0000_8000;
        px  = sum[32:16];
        if (px > 17'sd32767)
            return 16'sh7FFF;
        else if (px < -17'sd32768)
            return 16'sh8000;
        else
            return px[15:0];
    endfunction

    // Clamp the 35-bit area to the 32-bit signed output range.
    function automatic logic signed [31:0] sat_area(input logic signed [34:0] a);
        if (a > 35'sd2147483647)
            return 32'sh7FFF_FFFF;
        else if (a < -35'sd2147483648)
            return 32'sh8000_0000;
        else
            return a[31:0];
    endfunction

    state_t             state;
    logic               in_ready_q;
    logic        [15:0] stat_emitted_q;
    logic        [15:0] stat_culled_q;
    logic signed [15:0] vx_p0 [3];
    logic signed [15:0] vy_p0 [3];

    logic [ENT_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               xfer;
    logic               pop;
    logic               full;
    logic               can_push;
    logic               reject_p1;
    logic               drop_p1;
    logic               push_vld_p1;
    logic signed [16:0] dx1, dy1, dx2, dy2;
    logic signed [34:0] prod_a, prod_b, area_raw;
    logic signed [31:0] area_p1;
    logic [ENT_W-1:0]   entry_p1;
    logic [ENT_W-1:0]   head;

    assign xfer     = bus.in_valid & in_ready_q;
    assign pop      = bus.out_valid & bus.out_ready;
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign can_push = !full || pop;

    // Stage 0: capture rounded vertices as they are accepted
    always_ff @(posedge clk) begin
        if (xfer) begin
            case (state)
                S_V0:    begin vx_p0[0] <= round_px(bus.in_x); vy_p0[0] <= round_px(bus.in_y); end
                S_V1:    begin vx_p0[1] <= round_px(bus.in_x); vy_p0[1] <= round_px(bus.in_y); end
                S_V2:    begin vx_p0[2] <= round_px(bus.in_x); vy_p0[2] <= round_px(bus.in_y); end
                default: ;
            endcase
        end
    end

    // Stage 1: area and reject/cull decision from the held vertices
    assign dx1      = {vx_p0[1][15], vx_p0[1]} - {vx_p0[0][15], vx_p0[0]};
    assign dy1      = {vy_p0[1][15], vy_p0[1]} - {vy_p0[0][15], vy_p0[0]};
    assign dx2      = {vx_p0[2][15], vx_p0[2]} - {vx_p0[0][15], vx_p0[0]};
    assign dy2      = {vy_p0[2][15], vy_p0[2]} - {vy_p0[0][15], vy_p0[0]};
    assign prod_a   = {{18{dx1[16]}}, dx1} * {{18{dy2[16]}}, dy2};
    assign prod_b   = {{18{dx2[16]}}, dx2} * {{18{dy1[16]}}, dy1};
    assign area_raw = prod_a - prod_b;
    assign area_p1  = sat_area(area_raw);

    assign reject_p1 =
        (vx_p0[0][15] && vx_p0[1][15] && vx_p0[2][15]) ||
        (vy_p0[0][15] && vy_p0[1][15] && vy_p0[2][15]) ||
        (int'(vx_p0[0]) >= SCREEN_W && int'(vx_p0[1]) >= SCREEN_W && int'(vx_p0[2]) >= SCREEN_W) ||
        (int'(vy_p0[0]) >= SCREEN_H && int'(vy_p0[1]) >= SCREEN_H && int'(vy_p0[2]) >= SCREEN_H);

    assign drop_p1     = reject_p1 || (bus.cull_en && (area_p1 <= 32'sd0));
    assign push_vld_p1 = ((state == S_EVAL && !drop_p1) || state == S_STALL) && can_push;
    assign entry_p1    = {vx_p0[0], vy_p0[0], vx_p0[1], vy_p0[1], vx_p0[2], vy_p0[2], area_p1};

    // Assembly FSM with registered ready and saturating statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_V0;
            in_ready_q     <= 1'b1;
            stat_emitted_q <= '0;
            stat_culled_q  <= '0;
        end else begin
            unique case (state)
                S_V0: if (xfer) state <= S_V1;
                S_V1: if (xfer) state <= S_V2;
                S_V2: if (xfer) begin
                    state      <= S_EVAL;
                    in_ready_q <= 1'b0;
                end
                S_EVAL: begin
                    if (drop_p1) begin
                        if (stat_culled_q != 16'hFFFF) stat_culled_q <= stat_culled_q + 16'd1;
                        state      <= S_V0;
                        in_ready_q <= 1'b1;
                    end else if (can_push) begin
                        if (stat_emitted_q != 16'hFFFF) stat_emitted_q <= stat_emitted_q + 16'd1;
                        state      <= S_V0;
                        in_ready_q <= 1'b1;
                    end else begin
                        state <= S_STALL;
                    end
                end
                S_STALL: if (can_push) begin
                    if (stat_emitted_q != 16'hFFFF) stat_emitted_q <= stat_emitted_q + 16'd1;
                    state      <= S_V0;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state      <= S_V0;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Stage 2: FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld_p1) wr_ptr <= wr_ptr + 1'b1;
            if (pop)         rd_ptr <= rd_ptr + 1'b1;
            case ({push_vld_p1, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // FIFO storage write; a push into an empty FIFO is visible next cycle
    always_ff @(posedge clk) begin
        if (push_vld_p1) mem[wr_ptr] <= entry_p1;
    end

    assign head             = mem[rd_ptr];
    assign bus.out_valid    = (count != '0);
    assign bus.out_x0       = bus.out_valid ? head[127:112] : '0;
    assign bus.out_y0       = bus.out_valid ? head[111:96]  : '0;
    assign bus.out_x1       = bus.out_valid ? head[95:80]   : '0;
    assign bus.out_y1       = bus.out_valid ? head[79:64]   : '0;
    assign bus.out_x2       = bus.out_valid ? head[63:48]   : '0;
    assign bus.out_y2       = bus.out_valid ? head[47:32]   : '0;
    assign bus.out_area     = bus.out_valid ? head[31:0]    : '0;
    assign bus.in_ready     = in_ready_q;
    assign bus.stat_emitted = stat_emitted_q;
    assign bus.stat_culled  = stat_culled_q;
endmodule

// File: tb/tb_tri_assembler.sv
// Bench for tri_assembler: directed vector table, stall/reset sequences and
// randomized triangles scored against a pixel-arithmetic reference model.
module tb_tri_assembler;
    logic clk = 1'b0;
    logic rst = 1'b1;

    tri_if bus();

    tri_assembler #(.FIFO_DEPTH(4), .SCREEN_W(600), .SCREEN_H(600)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int x0, y0, x1, y1, x2, y2;
        int area;
    } tri_t;

    typedef struct {
        int x0, y0, x1, y1, x2, y2;   // Q16.16 inputs
        bit cull;
        bit emit;
        int px0, py0, px1, py1, px2, py2;
        int area;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    tri_t exp_q[$];
    int   mv_x[3];
    int   mv_y[3];
    int   nv = 0;
    bit   eval_pend = 0;
    int   exp_emit = 0;
    int   exp_cull = 0;
    bit   acc = 0;
    bit   rand_rdy = 0;
    vec_t tbl[11];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int m_round(input int q);
        longint v;
        v = (longint'(q) + 64'sd32768) >>> 16;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return int'(v);
    endfunction

    function automatic int m_area(input int x0, y0, x1, y1, x2, y2);
        longint a;
        a = longint'(x1 - x0) * longint'(y2 - y0) - longint'(x2 - x0) * longint'(y1 - y0);
        if (a > 64'sd2147483647) a = 64'sd2147483647;
        if (a < -64'sd2147483648) a = -64'sd2147483648;
        return int'(a);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        nv = 0;
        eval_pend = 0;
        exp_emit = 0;
        exp_cull = 0;
    endtask

    task automatic model_eval(input bit cull);
        tri_t t;
        bit   rej;
        t.x0 = mv_x[0]; t.y0 = mv_y[0];
        t.x1 = mv_x[1]; t.y1 = mv_y[1];
        t.x2 = mv_x[2]; t.y2 = mv_y[2];
        t.area = m_area(t.x0, t.y0, t.x1, t.y1, t.x2, t.y2);
        rej = (t.x0 < 0 && t.x1 < 0 && t.x2 < 0) ||
              (t.y0 < 0 && t.y1 < 0 && t.y2 < 0) ||
              (t.x0 >= 600 && t.x1 >= 600 && t.x2 >= 600) ||
              (t.y0 >= 600 && t.y1 >= 600 && t.y2 >= 600);
        if (rej || (cull && t.area <= 0)) exp_cull++;
        else begin
            exp_q.push_back(t);
            exp_emit++;
        end
    endtask

    // One clock: observe at the falling edge, then return 1ns after the rising edge.
    task automatic tick();
        tri_t t;
        @(negedge clk);
        acc = 0;
        if (eval_pend) begin
            eval_pend = 0;
            model_eval(bus.cull_en);
        end
        if (bus.in_valid && bus.in_ready) begin
            mv_x[nv] = m_round(bus.in_x);
            mv_y[nv] = m_round(bus.in_y);
            acc = 1;
            nv++;
            if (nv == 3) begin
                nv = 0;
                eval_pend = 1;
            end
        end
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pop", 1, 0);
            end else begin
                t = exp_q.pop_front();
                check("sb_x0", bus.out_x0, t.x0);
                check("sb_y0", bus.out_y0, t.y0);
                check("sb_x1", bus.out_x1, t.x1);
                check("sb_y1", bus.out_y1, t.y1);
                check("sb_x2", bus.out_x2, t.x2);
                check("sb_y2", bus.out_y2, t.y2);
                check("sb_area", bus.out_area, t.area);
            end
        end
        @(posedge clk);
        #1;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_vertex(input int qx, input int qy);
        bus.in_x = qx;
        bus.in_y = qy;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (acc) break;
        end
        if (!acc) check("vertex_accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_tri(input int x0, y0, x1, y1, x2, y2);
        send_vertex(x0, y0);
        send_vertex(x1, y1);
        send_vertex(x2, y2);
    endtask

    function automatic int rq();
        return int'($urandom_range(0, 800 * 65536)) - 100 * 65536;
    endfunction

    initial begin
        int e0, c0;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.cull_en   = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();

        tbl[0]  = '{32'h00640000, 32'h00640000, 32'h00C80000, 32'h00640000, 32'h00640000, 32'h00C80000,
                    1'b1, 1'b1, 100, 100, 200, 100, 100, 200, 10000};
        tbl[1]  = '{32'h00640000, 32'h00640000, 32'h00640000, 32'h00C80000, 32'h00C80000, 32'h00640000,
                    1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{32'h00640000, 32'h00640000, 32'h00640000, 32'h00C80000, 32'h00C80000, 32'h00640000,
                    1'b0, 1'b1, 100, 100, 100, 200, 200, 100, -10000};
        tbl[3]  = '{32'h00008000, 32'h000A0000, 32'hFFFF8000, 32'h00140000, 32'h7FFFFFFF, 32'h001E0000,
                    1'b0, 1'b1, 1, 10, 0, 20, 32767, 30, -327680};
        tbl[4]  = '{32'hFFF60000, 32'h00640000, 32'hFFF60000, 32'h00C80000, 32'hFFF60000, 32'h00320000,
                    1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{32'h02578000, 32'h00000000, 32'h02578000, 32'h000A0000, 32'h02578000, 32'h00140000,
                    1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{32'h000A0000, 32'h02580000, 32'h00140000, 32'h02580000, 32'h001E0000, 32'h02580000,
                    1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{32'h02576666, 32'h00000000, 32'h02576666, 32'h000A0000, 32'h02576666, 32'h00140000,
                    1'b0, 1'b1, 599, 0, 599, 10, 599, 20, 0};
        tbl[8]  = '{32'h000A0000, 32'h000A0000, 32'h00140000, 32'h00140000, 32'h001E0000, 32'h001E0000,
                    1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{32'h80000000, 32'h80000000, 32'h7FFF0000, 32'h80000000, 32'h80000000, 32'h7FFF0000,
                    1'b1, 1'b1, -32768, -32768, 32767, -32768, -32768, 32767, 32'h7FFFFFFF};
        tbl[10] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h7FFF0000, 32'h7FFF0000, 32'h80000000,
                    1'b0, 1'b1, -32768, -32768, -32768, 32767, 32767, -32768, 32'h80000000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_stat_emitted", bus.stat_emitted, 0);
        check("rst_stat_culled", bus.stat_culled, 0);
        check("rst_out_x0", bus.out_x0, 0);
        check("rst_out_area", bus.out_area, 0);

        // Directed vector table
        foreach (tbl[k]) begin
            bus.out_ready = 1'b0;
            bus.cull_en   = tbl[k].cull;
            e0 = int'(bus.stat_emitted);
            c0 = int'(bus.stat_culled);
            send_tri(tbl[k].x0, tbl[k].y0, tbl[k].x1, tbl[k].y1, tbl[k].x2, tbl[k].y2);
            check($sformatf("v%0d_valid_at_n", k), bus.out_valid, 0);
            tick();
            check($sformatf("v%0d_valid_at_n1", k), bus.out_valid, tbl[k].emit);
            check($sformatf("v%0d_emitted", k), bus.stat_emitted, e0 + int'(tbl[k].emit));
            check($sformatf("v%0d_culled", k), bus.stat_culled, c0 + int'(!tbl[k].emit));
            if (tbl[k].emit) begin
                check($sformatf("v%0d_x0", k), bus.out_x0, tbl[k].px0);
                check($sformatf("v%0d_y0", k), bus.out_y0, tbl[k].py0);
                check($sformatf("v%0d_x1", k), bus.out_x1, tbl[k].px1);
                check($sformatf("v%0d_y1", k), bus.out_y1, tbl[k].py1);
                check($sformatf("v%0d_x2", k), bus.out_x2, tbl[k].px2);
                check($sformatf("v%0d_y2", k), bus.out_y2, tbl[k].py2);
                check($sformatf("v%0d_area", k), bus.out_area, tbl[k].area);
            end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            check($sformatf("v%0d_drained", k), bus.out_valid, 0);
        end

        // Full FIFO: fifth triangle stalls, then pushes on the cycle of a pop
        bus.out_ready = 1'b0;
        bus.cull_en   = 1'b1;
        e0 = int'(bus.stat_emitted);
        for (int k = 0; k < 5; k++)
            send_tri((100 + k) << 16, 100 << 16, (200 + k) << 16, 100 << 16, (100 + k) << 16, 200 << 16);
        tick();
        tick();
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_emitted", bus.stat_emitted, e0 + 4);
        check("stall_head_x0", bus.out_x0, 100);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("stall_release_emitted", bus.stat_emitted, e0 + 5);
        check("stall_release_in_ready", bus.in_ready, 1);
        check("stall_release_valid", bus.out_valid, 1);
        check("stall_release_head_x0", bus.out_x0, 101);
        bus.out_ready = 1'b1;
        repeat (6) tick();
        bus.out_ready = 1'b0;
        check("stall_drain_valid", bus.out_valid, 0);
        check("stall_drain_queue", exp_q.size(), 0);

        // Reset mid-triangle with two triangles queued
        send_tri(300 << 16, 100 << 16, 400 << 16, 100 << 16, 300 << 16, 200 << 16);
        send_tri(310 << 16, 100 << 16, 410 << 16, 100 << 16, 310 << 16, 200 << 16);
        send_vertex(20 << 16, 20 << 16);
        send_vertex(30 << 16, 40 << 16);
        check("pre_rst_valid", bus.out_valid, 1);
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_emitted", bus.stat_emitted, 0);
        check("mid_rst_culled", bus.stat_culled, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        send_tri(50 << 16, 60 << 16, 150 << 16, 60 << 16, 50 << 16, 160 << 16);
        tick();
        check("post_rst_valid", bus.out_valid, 1);
        check("post_rst_x0", bus.out_x0, 50);
        check("post_rst_y2", bus.out_y2, 160);
        check("post_rst_area", bus.out_area, 10000);
        check("post_rst_emitted", bus.stat_emitted, 1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Randomized triangles against the reference model
        rand_rdy = 1'b1;
        for (int t = 0; t < 300; t++) begin
            bus.cull_en = 1'($urandom_range(0, 1));
            for (int v = 0; v < 3; v++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_vertex(rq(), rq());
            end
        end
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) tick();
        check("rand_final_valid", bus.out_valid, 0);
        check("rand_final_queue", exp_q.size(), 0);
        check("rand_final_emitted", bus.stat_emitted, exp_emit);
        check("rand_final_culled", bus.stat_culled, exp_cull);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
